// File: rtl/hilo_muldiv_unit_if.sv
// Bus between the EX stage and the HI/LO multiply/divide unit.
//
// Handshake: Start/Op/A/B form a request that the unit samples on a rising
// Clk edge only while Busy=0. A request presented while Busy=1 is dropped,
// not queued, so the pipeline keeps presenting it until Busy falls. Long
// operations end with a one-cycle Done pulse; Done and Busy are never both 1.
// dbg_state mirrors the internal FSM state (0 IDLE, 1 RUN, 2 FIX).
interface hilo_muldiv_unit_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic [1:0]  dbg_state;

  modport master (
    output Start, Op, A, B,
    input  Hi, Lo, Busy, Done, dbg_state
  );

  modport slave (
    input  Start, Op, A, B,
    output Hi, Lo, Busy, Done, dbg_state
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One multiplier bit (shift-add) or one quotient bit (restoring division)
// per cycle; signed ops run on magnitudes and are fixed up in FIX.
// Optional feature macro: MULDIV_DIV_EN compiles in the divider and the
// DIV/DIVU ops; without it Op 010/011 are no-ops.
module hilo_muldiv_unit (
  input  logic              Clk,
  input  logic              Reset_n,
  hilo_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: low word holds dividend bits shifting out / quotient bits in.
  logic [63:0] acc_q, acc_d;
  // Multiplicand magnitude or divisor magnitude.
  logic [31:0] opb_q, opb_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        op_mul;
  logic        op_signed;
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;

`ifdef MULDIV_DIV_EN
  logic        op_div;
  logic        is_div_q, is_div_d;
  // Stored remainder is always below the divisor, so 32 bits hold it; the
  // 33-bit partial remainder exists only as div_shift during a step.
  logic [31:0] rem_q, rem_d;
  // Raw dividend kept for the divide-by-zero result.
  logic [31:0] a_raw_q, a_raw_d;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
`endif

  // Request decode and per-cycle datapath arithmetic
  always_comb begin
    op_mul    = (bus.Op[2:1] == 2'b00);
    op_signed = ~bus.Op[0];
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    prod_fix  = (sign_a_q ^ sign_b_q) ? (~acc_q + 64'd1) : acc_q;
`ifdef MULDIV_DIV_EN
    op_div    = (bus.Op[2:1] == 2'b01);
    div_shift = {rem_q, acc_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
`endif
  end

  // FSM next state, datapath updates and HI/LO writes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULDIV_DIV_EN
    is_div_d = is_div_q;
    rem_d    = rem_q;
    a_raw_d  = a_raw_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (op_mul) begin
            sign_a_d = op_signed & bus.A[31];
            sign_b_d = op_signed & bus.B[31];
            opb_d    = neg_if(bus.A, op_signed & bus.A[31]);
            acc_d    = {32'd0, neg_if(bus.B, op_signed & bus.B[31])};
            cnt_d    = 6'd0;
            state_d  = RUN;
`ifdef MULDIV_DIV_EN
            is_div_d = 1'b0;
          end else if (op_div) begin
            sign_a_d = op_signed & bus.A[31];
            sign_b_d = op_signed & bus.B[31];
            acc_d    = {32'd0, neg_if(bus.A, op_signed & bus.A[31])};
            opb_d    = neg_if(bus.B, op_signed & bus.B[31]);
            rem_d    = 32'd0;
            a_raw_d  = bus.A;
            is_div_d = 1'b1;
            cnt_d    = 6'd0;
            state_d  = RUN;
`endif
          end else if (bus.Op == OP_MTHI) begin
            hi_d = bus.A;
          end else if (bus.Op == OP_MTLO) begin
            lo_d = bus.A;
          end
        end
      end

      RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = FIX;
        end
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          if (!div_diff[33]) begin
            rem_d = div_diff[31:0];
            acc_d = {acc_q[63:32], acc_q[30:0], 1'b1};
          end else begin
            rem_d = div_shift[31:0];
            acc_d = {acc_q[63:32], acc_q[30:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
`else
        acc_d = {mul_sum, acc_q[31:1]};
`endif
      end

      FIX: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
        done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          if (opb_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = a_raw_q;
          end else begin
            lo_d = neg_if(acc_q[31:0], sign_a_q ^ sign_b_q);
            hi_d = neg_if(rem_q, sign_a_q);
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
`else
        {hi_d, lo_d} = prod_fix;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      rem_q    <= 32'd0;
      a_raw_q  <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MULDIV_DIV_EN
      is_div_q <= is_div_d;
      rem_q    <= rem_d;
      a_raw_q  <= a_raw_d;
`endif
    end
  end

  // Outputs straight from registers
  always_comb begin
    bus.Hi        = hi_q;
    bus.Lo        = lo_q;
    bus.Busy      = (state_q != IDLE);
    bus.Done      = done_q;
    bus.dbg_state = state_q;
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: reset/abort, MTHI/MTLO, signed and
// unsigned multiplies, divides (or divide-as-no-op without MULDIV_DIV_EN),
// Busy/Done cycle timing and dropped requests while busy.
module tb_hilo_muldiv_unit;

  logic Clk;
  logic Reset_n;
  int   n_vec;
  int   n_err;
  int   done_seen;

  hilo_muldiv_unit_if bus ();

  hilo_muldiv_unit dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one edge, then settle before sampling
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    bus.Start = s;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one long op at the next edge (E0) and follow it to its Done pulse.
  // inject_at > 0 presents an MTLO request before that edge, which must drop.
  task automatic run_long(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int inject_at,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] hi0;
    logic [31:0] lo0;
    int busy_n;
    int done_at;
    int overlap;
    hi0 = bus.Hi;
    lo0 = bus.Lo;
    drive(1'b1, op, a, b);
    tick();
    drive(1'b0, 3'b111, $urandom, $urandom);
    check({tag, "_busy_rise"}, {31'd0, bus.Busy}, 32'd1);
    check({tag, "_done_clr"}, {31'd0, bus.Done}, 32'd0);
    busy_n  = 0;
    done_at = -1;
    overlap = 0;
    for (int e = 1; e <= 40 && done_at < 0; e++) begin
      if (bus.Busy) busy_n++;
      if (e == inject_at) drive(1'b1, 3'b101, 32'h5555_AAAA, 32'd0);
      tick();
      if (e == inject_at) drive(1'b0, 3'b111, $urandom, $urandom);
      if (bus.Busy && bus.Done) overlap++;
      if (e == 32) begin
        check({tag, "_hold_hi"}, bus.Hi, hi0);
        check({tag, "_hold_lo"}, bus.Lo, lo0);
      end
      if (bus.Done) done_at = e;
    end
    check({tag, "_busy_cycles"}, busy_n, 32'd33);
    check({tag, "_done_edge"}, done_at, 32'd33);
    check({tag, "_overlap"}, overlap, 32'd0);
    check({tag, "_hi"}, bus.Hi, exp_hi);
    check({tag, "_lo"}, bus.Lo, exp_lo);
    check({tag, "_busy_end"}, {31'd0, bus.Busy}, 32'd0);
  endtask

  // Directed sequence
  initial begin
    n_vec   = 0;
    n_err   = 0;
    Reset_n = 1'b0;
    drive(1'b0, 3'b111, 32'd0, 32'd0);
    repeat (2) tick();
    check("rst_hi", bus.Hi, 32'd0);
    check("rst_lo", bus.Lo, 32'd0);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_done", {31'd0, bus.Done}, 32'd0);
    check("rst_state", {30'd0, bus.dbg_state}, 32'd0);
    Reset_n = 1'b1;
    tick();

    // Load HI/LO, then abort a MULT 7x9 mid-RUN with reset
    drive(1'b1, 3'b100, 32'h1111_1111, 32'd0);
    tick();
    drive(1'b1, 3'b101, 32'h2222_2222, 32'd0);
    tick();
    check("pre_abort_hi", bus.Hi, 32'h1111_1111);
    check("pre_abort_lo", bus.Lo, 32'h2222_2222);
    drive(1'b1, 3'b000, 32'd7, 32'd9);
    tick();
    drive(1'b0, 3'b111, 32'd0, 32'd0);
    check("abort_busy_on", {31'd0, bus.Busy}, 32'd1);
    repeat (5) tick();
    Reset_n = 1'b0;
    #1;
    check("abort_hi", bus.Hi, 32'd0);
    check("abort_lo", bus.Lo, 32'd0);
    check("abort_busy", {31'd0, bus.Busy}, 32'd0);
    check("abort_done", {31'd0, bus.Done}, 32'd0);
    repeat (2) tick();
    Reset_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.Done) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);
    check("abort_hi_kept", bus.Hi, 32'd0);
    check("abort_lo_kept", bus.Lo, 32'd0);

    // MTHI then MTLO back-to-back, then MULTU on the very next edge
    drive(1'b1, 3'b100, 32'hDEAD_BEEF, 32'd0);
    tick();
    check("mthi_hi", bus.Hi, 32'hDEAD_BEEF);
    check("mthi_lo", bus.Lo, 32'd0);
    check("mthi_busy", {31'd0, bus.Busy}, 32'd0);
    check("mthi_done", {31'd0, bus.Done}, 32'd0);
    drive(1'b1, 3'b101, 32'h0BAD_F00D, 32'd0);
    tick();
    check("mtlo_lo", bus.Lo, 32'h0BAD_F00D);
    check("mtlo_hi", bus.Hi, 32'hDEAD_BEEF);
    check("mtlo_busy", {31'd0, bus.Busy}, 32'd0);
    check("mtlo_done", {31'd0, bus.Done}, 32'd0);
    run_long("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,
             32'hFFFF_FFFE, 32'h0000_0001);

    // Accepted at E34 of the previous op; MTLO at E10 must be dropped
    run_long("mult_m3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 10,
             32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_long("mult_m4xm6", 3'b000, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 0,
             32'd0, 32'd24);
    run_long("mult_maxxm1", 3'b000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0,
             32'hFFFF_FFFF, 32'h8000_0001);
    run_long("multu_shift", 3'b001, 32'h1234_5678, 32'h0000_0100, 0,
             32'h0000_0012, 32'h3456_7800);

    // Op 11x is a no-op
    drive(1'b1, 3'b110, 32'hCAFE_0000, 32'd1);
    tick();
    drive(1'b1, 3'b111, 32'hCAFE_0001, 32'd1);
    tick();
    drive(1'b0, 3'b111, 32'd0, 32'd0);
    check("nop_busy", {31'd0, bus.Busy}, 32'd0);
    check("nop_done", {31'd0, bus.Done}, 32'd0);
    check("nop_hi", bus.Hi, 32'h0000_0012);
    check("nop_lo", bus.Lo, 32'h3456_7800);

`ifdef MULDIV_DIV_EN
    run_long("div_m7d2", 3'b010, 32'hFFFF_FFF9, 32'd2, 0,
             32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_long("divu_100d7", 3'b011, 32'd100, 32'd7, 0, 32'd2, 32'd14);
    run_long("divu_by0", 3'b011, 32'h0000_1234, 32'd0, 0,
             32'h0000_1234, 32'hFFFF_FFFF);
    run_long("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0,
             32'd0, 32'h8000_0000);
    run_long("div_7dm2", 3'b010, 32'd7, 32'hFFFF_FFFE, 0,
             32'd1, 32'hFFFF_FFFD);
    run_long("div_m5by0", 3'b010, 32'hFFFF_FFFB, 32'd0, 0,
             32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_long("divu_max", 3'b011, 32'hFFFF_FFFF, 32'd2, 0,
             32'd1, 32'h7FFF_FFFF);
`else
    // Without the divider DIV/DIVU are ignored entirely
    drive(1'b1, 3'b010, 32'hFFFF_FFF9, 32'd2);
    tick();
    drive(1'b0, 3'b111, 32'd0, 32'd0);
    check("nodiv_div_busy", {31'd0, bus.Busy}, 32'd0);
    drive(1'b1, 3'b011, 32'd100, 32'd7);
    tick();
    drive(1'b0, 3'b111, 32'd0, 32'd0);
    check("nodiv_divu_busy", {31'd0, bus.Busy}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.Done || bus.Busy) done_seen++;
    end
    check("nodiv_quiet", done_seen, 32'd0);
    check("nodiv_hi", bus.Hi, 32'h0000_0012);
    check("nodiv_lo", bus.Lo, 32'h3456_7800);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
